// File: rtl/led_ctrl.sv
// led_ctrl: switch-selected LED pattern generator.
// A 3-bit switch bank passes through a two-flop synchronizer and picks one of
// eight patterns. All patterns are derived from one free-running prescaler,
// so switching modes never resets the pattern phase.
module led_ctrl #(
  parameter int CNT_W = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sw,
  output logic       led
);

  localparam logic [2:0] M_OFF   = 3'b000;
  localparam logic [2:0] M_ON    = 3'b001;
  localparam logic [2:0] M_SLOW  = 3'b010;
  localparam logic [2:0] M_FAST  = 3'b011;
  localparam logic [2:0] M_PWM25 = 3'b100;
  localparam logic [2:0] M_PWM50 = 3'b101;
  localparam logic [2:0] M_PWM75 = 3'b110;
  localparam logic [2:0] M_BRTH  = 3'b111;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       sw_m_q, sw_m_d;
  logic [2:0]       sw_s_q, sw_s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             led_q, led_d;
  logic [7:0]       breath_duty;
  logic [7:0]       pwm_phase;

  // Synchronizer shift and prescaler increment (wraps naturally at 2^CNT_W).
  always_comb begin
    sw_m_d = sw;
    sw_s_d = sw_m_q;
    cnt_d  = cnt_q + CNT_ONE;
  end

  // Pattern select; uses the pre-increment count so led lags cnt by one edge.
  always_comb begin
    pwm_phase   = cnt_q[7:0];
    // Triangle over the full count period: ramp up in the first half,
    // mirror back down in the second, constant within each 256-cycle window.
    breath_duty = cnt_q[CNT_W-1] ? ~cnt_q[CNT_W-2 -: 8] : cnt_q[CNT_W-2 -: 8];
    led_d       = 1'b0;
    unique case (sw_s_q)
      M_OFF:   led_d = 1'b0;
      M_ON:    led_d = 1'b1;
      M_SLOW:  led_d = cnt_q[CNT_W-1];
      M_FAST:  led_d = cnt_q[CNT_W-3];
      M_PWM25: led_d = (pwm_phase < 8'd64);
      M_PWM50: led_d = (pwm_phase < 8'd128);
      M_PWM75: led_d = (pwm_phase < 8'd192);
      M_BRTH:  led_d = (pwm_phase < breath_duty);
      default: led_d = 1'b0;
    endcase
  end

  // Switch synchronizer; cleared so the mode reads as off until refilled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_m_q <= 3'b000;
      sw_s_q <= 3'b000;
    end else begin
      sw_m_q <= sw_m_d;
      sw_s_q <= sw_s_d;
    end
  end

  // Free-running prescaler; only reset restarts it, never a mode change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Registered LED drive; async reset darkens it without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) led_q <= 1'b0;
    else     led_q <= led_d;
  end

  assign led = led_q;

endmodule

// File: tb/tb_led_ctrl.sv
// tb_led_ctrl: directed checks of led_ctrl at CNT_W=17.
// Inputs change and outputs are sampled 1ns after each rising edge.
// ncnt tracks how many edges the prescaler has seen since reset release,
// so after a tick the led reflects pattern phase (ncnt-1).
module tb_led_ctrl;

  localparam int CW  = 17;
  localparam int PER = 1 << CW;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] sw;
  logic       led;

  int n_chk = 0;
  int n_err = 0;
  int ncnt  = 0;
  int hi_w [512];

  led_ctrl #(.CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw),
    .led (led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst) ncnt = (ncnt + 1) % PER;
  endtask

  // Advance until led reaches v or lim edges elapse; cyc returns edges used.
  task automatic wait_led(input string tag, input logic v, input int lim, output int cyc);
    cyc = 0;
    while (led !== v && cyc < lim) begin
      tick();
      cyc++;
    end
    chk(tag, {31'd0, led}, {31'd0, v});
  endtask

  // Four aligned PWM windows: exactly d high cycles, all at the window start.
  task automatic pwm(input logic [2:0] m, input int d);
    int hi, bad;
    sw = m;
    repeat (3) tick();
    while ((ncnt & 255) != 0) tick();
    for (int w = 0; w < 4; w++) begin
      hi  = 0;
      bad = 0;
      for (int k = 0; k < 256; k++) begin
        tick();
        hi += int'(led);
        if (led !== (k < d)) bad++;
      end
      chk($sformatf("pwm%0d_hi_w%0d", d, w), hi, d);
      chk($sformatf("pwm%0d_pos_w%0d", d, w), bad, 0);
    end
  endtask

  initial begin
    int hi, lo, cyc, t_rise, t_fall, t_rise2, brk;

    // Reset with sw=001 held; led dark during reset, lit on 3rd edge after.
    rst = 1'b1;
    sw  = 3'b001;
    tick();
    tick();
    chk("rst_led", {31'd0, led}, 0);
    chk("rst_cnt", dut.cnt_q, 0);
    rst  = 1'b0;
    ncnt = 0;
    tick();
    chk("lat_e1", {31'd0, led}, 0);
    chk("cnt_e1", dut.cnt_q, 1);
    tick();
    chk("lat_e2", {31'd0, led}, 0);
    tick();
    chk("lat_e3", {31'd0, led}, 1);
    chk("cnt_e3", dut.cnt_q, 3);

    // Off then on.
    sw = 3'b000;
    repeat (3) tick();
    hi = 0;
    repeat (512) begin tick(); hi += int'(led); end
    chk("m000_hi", hi, 0);
    sw = 3'b001;
    repeat (3) tick();
    lo = 0;
    repeat (512) begin tick(); lo += int'(!led); end
    chk("m001_lo", lo, 0);

    pwm(3'b100, 64);
    pwm(3'b101, 128);
    pwm(3'b110, 192);

    // Fast blink: cnt[14] edges at 16384, 32768, 49152.
    sw = 3'b011;
    repeat (3) tick();
    chk("fb_start_low", {31'd0, led}, 0);
    wait_led("fb_rise_to", 1'b1, 20000, cyc);
    t_rise = ncnt;
    chk("fb_rise_at", t_rise, 16385);
    wait_led("fb_fall_to", 1'b0, 20000, cyc);
    t_fall = ncnt;
    chk("fb_high_run", t_fall - t_rise, 16384);
    wait_led("fb_rise2_to", 1'b1, 20000, cyc);
    t_rise2 = ncnt;
    chk("fb_low_run", t_rise2 - t_fall, 16384);

    // Mid-pattern reset between edges while led is lit.
    #3;
    rst = 1'b1;
    #1;
    chk("mr_led", {31'd0, led}, 0);
    chk("mr_cnt", dut.cnt_q, 0);
    ncnt = 0;
    tick();
    chk("mr_hold_led", {31'd0, led}, 0);
    rst = 1'b0;
    repeat (3) tick();
    chk("mr_cnt3", dut.cnt_q, 3);
    chk("mr_led3", {31'd0, led}, 0);
    wait_led("mr_rise_to", 1'b1, 20000, cyc);
    chk("mr_rise_at", ncnt, 16385);

    // Breathing over one full period from a fresh reset with sw=111 held.
    sw  = 3'b111;
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    ncnt = 0;
    for (int w = 0; w < 512; w++) begin
      hi = 0;
      for (int k = 0; k < 256; k++) begin
        tick();
        hi += int'(led);
        // Lands slow blink exactly on the wrap edge, two edges later.
        if (w == 511 && k == 253) sw = 3'b010;
      end
      hi_w[w] = hi;
    end
    chk("br_w000", hi_w[0], 0);
    chk("br_w001", hi_w[1], 1);
    chk("br_w0FF", hi_w[255], 255);
    chk("br_w100", hi_w[256], 255);
    chk("br_w180", hi_w[384], 127);
    chk("br_w1FF", hi_w[511], 0);
    brk = 0;
    for (int w = 1; w < 256; w++) if (hi_w[w] < hi_w[w-1]) brk++;
    for (int w = 257; w < 512; w++) if (hi_w[w] > hi_w[w-1]) brk++;
    chk("br_mono", brk, 0);
    chk("wrap_cnt", dut.cnt_q, 0);

    // Slow blink from the wrap: dark for 65536 cycles, then lit.
    tick();
    lo = int'(!led);
    wait_led("sb_rise_to", 1'b1, 70000, cyc);
    lo += cyc - 1;
    chk("sb_low_run", lo, 65536);
    chk("sb_rise_at", ncnt, 65537);
    tick();
    chk("sb_stays_hi", {31'd0, led}, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
